// File: rtl/ofd_pat_pkg.sv
// Shared types and defaults for the pad test-pattern generator.
// Holds pattern width, length-counter width, PRBS taps, mode codes and FSM states.
package ofd_pat_pkg;

  localparam int PAT_W    = 5;
  localparam int PAT_LENW = 8;
  // x^5 + x^3 + 1
  localparam logic [PAT_W-1:0] PAT_TAPS = 5'b10100;

  typedef enum logic [1:0] {
    MODE_CNT    = 2'b00,
    MODE_WALK   = 2'b01,
    MODE_PRBS   = 2'b10,
    MODE_STATIC = 2'b11
  } mode_t;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_FIN  = 2'd2;

endpackage

// File: rtl/ofd_pat_step.sv
// Next-word rule for each pattern mode; purely combinational, no latency.
// No flow control: the caller decides when to register the result.
module ofd_pat_step
  import ofd_pat_pkg::*;
#(
  parameter int             W    = PAT_W,
  parameter logic [W-1:0]   TAPS = PAT_TAPS
) (
  input  mode_t          mode,
  input  logic [W-1:0]   q,
  output logic [W-1:0]   nxt
);

  always_comb begin
    nxt = q;
    case (mode)
      MODE_CNT:  nxt = q + 1'b1;
      MODE_WALK: nxt = {q[W-2:0], q[W-1]};
      MODE_PRBS: nxt = {q[W-2:0], ^(q & TAPS)};
      default:   nxt = q;
    endcase
  end

endmodule

// File: rtl/ofd_pat_gen.sv
// Burst pattern generator feeding the pad FF bank; one register stage, outputs registered.
// No backpressure: a burst runs to completion unless STOP aborts it.
module ofd_pat_gen
  import ofd_pat_pkg::*;
#(
  parameter int           W    = PAT_W,
  parameter int           LENW = PAT_LENW,
  parameter logic [W-1:0] TAPS = PAT_TAPS
) (
  input  logic            CK,
  input  logic            RN,
  input  logic            START,
  input  logic            STOP,
  input  logic [1:0]      MODE,
  input  logic [W-1:0]    SEED,
  input  logic [LENW-1:0] LEN,
  output logic [W-1:0]    PAT,
  output logic            VALID,
  output logic            BUSY,
  output logic            DONE
);

  state_t          state;
  mode_t           mode_r;
  logic [LENW-1:0] cnt;
  logic [W-1:0]    pat_q;
  logic            valid_q;
  logic            busy_q;
  logic            done_q;
  logic [W-1:0]    init_word;
  logic [W-1:0]    step_word;

  // An all-zero PRBS seed would lock the LFSR, so it is replaced by all-ones.
  always_comb begin
    init_word = SEED;
    case (mode_t'(MODE))
      MODE_WALK: init_word = {{(W-1){1'b0}}, 1'b1};
      MODE_PRBS: if (SEED == '0) init_word = '1;
      default:   init_word = SEED;
    endcase
  end

  ofd_pat_step #(
    .W    (W),
    .TAPS (TAPS)
  ) u_step (
    .mode (mode_r),
    .q    (pat_q),
    .nxt  (step_word)
  );

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state   <= ST_IDLE;
      mode_r  <= MODE_CNT;
      cnt     <= '0;
      pat_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (START && !STOP) begin
            state   <= ST_RUN;
            mode_r  <= mode_t'(MODE);
            cnt     <= LEN - 1'b1;
            pat_q   <= init_word;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ST_RUN: begin
          // cnt counts words still to come after the one on PAT now.
          if (STOP) begin
            state   <= ST_IDLE;
            pat_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end else if (cnt == '0) begin
            state   <= ST_FIN;
            pat_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            pat_q <= step_word;
            cnt   <= cnt - 1'b1;
          end
        end
        ST_FIN: begin
          done_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          state   <= ST_IDLE;
          pat_q   <= '0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign PAT   = pat_q;
  assign VALID = valid_q;
  assign BUSY  = busy_q;
  assign DONE  = done_q;

endmodule

// File: tb/tb_ofd_pat_gen.sv
// Scoreboard bench for ofd_pat_gen: stimulus pushes model words, a negedge monitor pops and compares.
module tb_ofd_pat_gen;

  logic       CK = 1'b0;
  logic       RN = 1'b0;
  logic       START = 1'b0;
  logic       STOP = 1'b0;
  logic [1:0] MODE = 2'd0;
  logic [4:0] SEED = 5'd0;
  logic [7:0] LEN = 8'd0;
  logic [4:0] PAT;
  logic       VALID;
  logic       BUSY;
  logic       DONE;

  int total = 0;
  int bad = 0;
  int exp_q[$];
  int seen_q[$];
  int done_seen = 0;
  int exp_done = 0;
  bit prev_valid = 1'b0;

  ofd_pat_gen dut (
    .CK    (CK),
    .RN    (RN),
    .START (START),
    .STOP  (STOP),
    .MODE  (MODE),
    .SEED  (SEED),
    .LEN   (LEN),
    .PAT   (PAT),
    .VALID (VALID),
    .BUSY  (BUSY),
    .DONE  (DONE)
  );

  always #5 CK = ~CK;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // i-th word of a burst, straight from the mode definitions.
  function automatic int model_word(input int m, input int seed, input int i);
    int q;
    case (m)
      0: return (seed + i) % 32;
      1: return 1 << (i % 5);
      2: begin
        q = (seed == 0) ? 31 : seed;
        for (int k = 0; k < i; k++) q = ((q << 1) & 31) | (((q >> 4) ^ (q >> 2)) & 1);
        return q;
      end
      default: return seed;
    endcase
  endfunction

  always @(negedge CK) begin
    if (RN) begin
      if (VALID) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: got %0d expected no word", PAT);
        end else begin
          chk("pat_word", int'(PAT), exp_q.pop_front());
        end
        seen_q.push_back(int'(PAT));
      end else begin
        chk("pat_zero_when_invalid", int'(PAT), 0);
      end
      chk("busy_eq_valid", int'(BUSY), int'(VALID));
      if (DONE) begin
        done_seen++;
        chk("done_after_last_word", int'(prev_valid), 1);
        chk("done_queue_empty", exp_q.size(), 0);
      end
      prev_valid = VALID;
    end
  end

  task automatic scramble();
    START = 1'($urandom_range(0, 1));
    MODE  = 2'($urandom_range(0, 3));
    SEED  = 5'($urandom_range(0, 31));
    LEN   = 8'($urandom_range(0, 255));
  endtask

  // stop_at>0: STOP asserted while word stop_at is on PAT.
  task automatic burst(input int m, input int s, input int l, input int stop_at, input bit noise);
    int n;
    int words;
    bit stopped;
    n = (l == 0) ? 256 : l;
    stopped = (stop_at > 0) && (stop_at <= n);
    words = stopped ? stop_at : n;
    for (int i = 0; i < words; i++) exp_q.push_back(model_word(m, s, i));
    if (!stopped) exp_done++;
    MODE = 2'(m);
    SEED = 5'(s);
    LEN = 8'(l);
    START = 1'b1;
    @(posedge CK); #1;
    START = 1'b0;
    if (stopped) begin
      repeat (stop_at - 1) begin
        @(posedge CK); #1;
        if (noise) scramble();
      end
      STOP = 1'b1;
      @(posedge CK); #1;
      STOP = 1'b0;
      START = 1'b0;
      chk("stop_valid_low", int'(VALID), 0);
    end else begin
      repeat (n + 1) begin
        @(posedge CK); #1;
        if (noise) scramble();
      end
      START = 1'b0;
    end
    repeat (2) @(posedge CK);
    #1;
    chk("done_count", done_seen, exp_done);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] mask;
    int s_r, l_r, st_r;
    #13;
    chk("reset_pat", int'(PAT), 0);
    chk("reset_valid", int'(VALID), 0);
    chk("reset_busy", int'(BUSY), 0);
    chk("reset_done", int'(DONE), 0);
    @(posedge CK); #1;
    RN = 1'b1;
    repeat (2) @(posedge CK);
    #1;

    burst(0, 30, 4, 0, 0);
    burst(1, 9, 6, 0, 0);
    burst(2, 1, 6, 0, 0);

    seen_q.delete();
    burst(2, 0, 31, 0, 0);
    mask = '0;
    foreach (seen_q[i]) mask[seen_q[i]] = 1'b1;
    chk("prbs_word_count", seen_q.size(), 31);
    chk("prbs_distinct_nonzero", $countones(mask), 31);
    chk("prbs_never_zero", int'(mask[0]), 0);

    burst(3, 15, 0, 0, 1);
    burst(0, 5, 10, 3, 0);

    MODE = 2'd0; LEN = 8'd3; START = 1'b1; STOP = 1'b1;
    @(posedge CK); #1;
    START = 1'b0; STOP = 1'b0;
    chk("start_stop_idle_valid", int'(VALID), 0);
    chk("start_stop_idle_busy", int'(BUSY), 0);
    repeat (2) @(posedge CK);
    #1;

    for (int i = 0; i < 20; i++) exp_q.push_back(model_word(0, 3, i));
    MODE = 2'd0; SEED = 5'd3; LEN = 8'd20; START = 1'b1;
    @(posedge CK); #1;
    START = 1'b0;
    repeat (4) @(posedge CK);
    #2;
    RN = 1'b0;
    #1;
    chk("rst_mid_pat", int'(PAT), 0);
    chk("rst_mid_valid", int'(VALID), 0);
    chk("rst_mid_busy", int'(BUSY), 0);
    chk("rst_mid_done", int'(DONE), 0);
    chk("rst_mid_words_seen", exp_q.size(), 16);
    exp_q.delete();
    prev_valid = 1'b0;
    @(posedge CK); #1;
    RN = 1'b1;
    repeat (2) @(posedge CK);
    #1;
    burst(0, 7, 2, 0, 0);

    for (int t = 0; t < 25; t++) begin
      l_r = int'($urandom_range(1, 40));
      s_r = int'($urandom_range(0, 31));
      st_r = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, l_r)) : 0;
      burst(int'($urandom_range(0, 3)), s_r, l_r, st_r, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
